// File: rtl/alu_pkg.sv
// Shared constants, shift-mode encoding and overflow helpers for the execute-stage ALU.
package alu_pkg;

  // Major opcodes
  localparam logic [5:0] OP_ARITH = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b101000;
  localparam logic [5:0] OP_XORI  = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b101100;
  localparam logic [5:0] OP_MOVI  = 6'b100010;

  // Function selects under OP_ARITH
  localparam logic [4:0] ADD   = 5'b00000;
  localparam logic [4:0] SUB   = 5'b00001;
  localparam logic [4:0] AND   = 5'b00010;
  localparam logic [4:0] XOR   = 5'b00011;
  localparam logic [4:0] OR    = 5'b00100;
  localparam logic [4:0] SLLI  = 5'b01000;
  localparam logic [4:0] SRLI  = 5'b01001;
  localparam logic [4:0] ROTRI = 5'b01011;
  // There is no dedicated no-op; the decoder emits a logical right shift.
  localparam logic [4:0] NOP   = SRLI;

  // Shift amount is always taken from the low five bits of operand 2.
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_ROTR = 2'b10
  } shift_mode_e;

  // Signed overflow of a+b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a-b: operands differ in sign, result sign differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational logarithmic barrel shifter: one stage per shift-amount bit,
// each stage conditionally moves the word by 2^k in the selected direction.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amt,
  input  shift_mode_e        mode,
  output logic [DATA_W-1:0]  result
);

  logic [DATA_W-1:0] stage [0:SHAMT_W];

  assign stage[0] = data;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [DATA_W-1:0] shifted;

    // Candidate value for this stage if bit k of the amount is set.
    always_comb begin
      case (mode)
        SH_SLL:  shifted = stage[k] << S;
        SH_SRL:  shifted = stage[k] >> S;
        SH_ROTR: shifted = (stage[k] >> S) | (stage[k] << (DATA_W - S));
        default: shifted = '0;
      endcase
    end

    assign stage[k+1] = amt[k] ? shifted : stage[k];
  end

  assign result = stage[SHAMT_W];

endmodule

// File: rtl/alu.sv
// Execute-stage integer ALU: decodes opcode/sub-opcode, computes the result and
// signed-overflow flag combinationally, and registers both on an enabled edge.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] scr1,
  input  logic [DATA_W-1:0] scr2,
  input  logic [5:0]        opcode,
  input  logic [4:0]        sub_opcode,
  input  logic              enable_execute,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_overflow
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] sh_out;
  shift_mode_e       sh_mode;
  logic [DATA_W-1:0] next_result;
  logic              next_ovf;

  assign sum  = scr1 + scr2;
  assign diff = scr1 - scr2;

  // Pick the shifter direction from the function select; right shift when idle.
  always_comb begin
    sh_mode = SH_SRL;
    case (sub_opcode)
      SLLI:    sh_mode = SH_SLL;
      ROTRI:   sh_mode = SH_ROTR;
      SRLI:    sh_mode = SH_SRL;
      default: sh_mode = SH_SRL;
    endcase
  end

  alu_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .data   (scr1),
    .amt    (scr2[SHAMT_W-1:0]),
    .mode   (sh_mode),
    .result (sh_out)
  );

  // Result/overflow mux; unknown encodings quietly produce zero.
  always_comb begin
    next_result = '0;
    next_ovf    = 1'b0;
    case (opcode)
      OP_ARITH: begin
        case (sub_opcode)
          ADD: begin
            next_result = sum;
            next_ovf    = add_ovf(scr1[DATA_W-1], scr2[DATA_W-1], sum[DATA_W-1]);
          end
          SUB: begin
            next_result = diff;
            next_ovf    = sub_ovf(scr1[DATA_W-1], scr2[DATA_W-1], diff[DATA_W-1]);
          end
          AND:   next_result = scr1 & scr2;
          XOR:   next_result = scr1 ^ scr2;
          OR:    next_result = scr1 | scr2;
          SLLI:  next_result = sh_out;
          SRLI:  next_result = sh_out;
          ROTRI: next_result = sh_out;
          default: begin
            next_result = '0;
            next_ovf    = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        next_result = sum;
        next_ovf    = add_ovf(scr1[DATA_W-1], scr2[DATA_W-1], sum[DATA_W-1]);
      end
      OP_XORI: next_result = scr1 ^ scr2;
      OP_ORI:  next_result = scr1 | scr2;
      OP_MOVI: next_result = scr2;
      default: begin
        next_result = '0;
        next_ovf    = 1'b0;
      end
    endcase
  end

  // Output register: cleared asynchronously by reset, and on any edge without the execute strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result   <= '0;
      alu_overflow <= 1'b0;
    end else if (enable_execute) begin
      alu_result   <= next_result;
      alu_overflow <= next_ovf;
    end else begin
      alu_result   <= '0;
      alu_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand-written sequences
// for reset/enable/hold behaviour, and random stimulus against a reference model.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] scr1;
  logic [31:0] scr2;
  logic [5:0]  opcode;
  logic [4:0]  sub_opcode;
  logic        enable_execute;
  logic [31:0] alu_result;
  logic        alu_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu #(.DATA_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .scr1           (scr1),
    .scr2           (scr2),
    .opcode         (opcode),
    .sub_opcode     (sub_opcode),
    .enable_execute (enable_execute),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (actual=running required=finished)");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0b required=%0b", name, act, exp);
    end
  endtask

  // Reference behaviour computed with wide signed arithmetic and a doubled word for rotation.
  function automatic void model(input logic [5:0] op, input logic [4:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic v);
    longint sa, sb, wide;
    logic [63:0] dbl;
    int amt;
    sa  = $signed(a);
    sb  = $signed(b);
    amt = int'(b % 32);
    r = 32'h0;
    v = 1'b0;
    if (op == OP_ADDI || (op == OP_ARITH && fn == ADD)) begin
      wide = sa + sb;
      r = wide[31:0];
      v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
    end else if (op == OP_ARITH && fn == SUB) begin
      wide = sa - sb;
      r = wide[31:0];
      v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
    end else if (op == OP_ARITH && fn == AND) r = a & b;
    else if ((op == OP_ARITH && fn == XOR) || op == OP_XORI) r = a ^ b;
    else if ((op == OP_ARITH && fn == OR) || op == OP_ORI) r = a | b;
    else if (op == OP_ARITH && fn == SLLI) r = a << amt;
    else if (op == OP_ARITH && fn == SRLI) r = a >> amt;
    else if (op == OP_ARITH && fn == ROTRI) begin
      dbl = {a, a} >> amt;
      r = dbl[31:0];
    end else if (op == OP_MOVI) r = b;
    else begin
      r = 32'h0;
      v = 1'b0;
    end
  endfunction

  task automatic drive(input logic [5:0] op, input logic [4:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic en);
    opcode = op;
    sub_opcode = fn;
    scr1 = a;
    scr2 = b;
    enable_execute = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  valid_ops [5];
  logic [4:0]  valid_fns [8];
  logic [31:0] exp_r;
  logic        exp_v;
  logic [5:0]  rop;
  logic [4:0]  rfn;
  logic        ren;

  initial begin
    vecs[0]  = '{OP_ARITH, ADD,      32'h0000162E, 32'h000004D2, 32'h00001B00, 1'b0};
    vecs[1]  = '{OP_ARITH, SUB,      32'h0000162E, 32'h000004D2, 32'h0000115C, 1'b0};
    vecs[2]  = '{OP_ARITH, AND,      32'h0000162E, 32'h000004D2, 32'h00000402, 1'b0};
    vecs[3]  = '{OP_ARITH, OR,       32'h0000162E, 32'h000004D2, 32'h000016FE, 1'b0};
    vecs[4]  = '{OP_ARITH, XOR,      32'h0000162E, 32'h000004D2, 32'h000012FC, 1'b0};
    vecs[5]  = '{OP_ARITH, NOP,      32'h0000162E, 32'h000004D2, 32'h00000000, 1'b0};
    vecs[6]  = '{OP_ARITH, SRLI,     32'h0000162E, 32'h00000003, 32'h000002C5, 1'b0};
    vecs[7]  = '{OP_ARITH, SLLI,     32'h0000162E, 32'h00000003, 32'h0000B170, 1'b0};
    vecs[8]  = '{OP_ARITH, ROTRI,    32'h0000162E, 32'h00000003, 32'hC00002C5, 1'b0};
    vecs[9]  = '{OP_ARITH, SRLI,     32'h0000162E, 32'h00000020, 32'h0000162E, 1'b0};
    vecs[10] = '{OP_ARITH, ROTRI,    32'h0000162E, 32'h00000000, 32'h0000162E, 1'b0};
    vecs[11] = '{OP_ARITH, SLLI,     32'h0000162E, 32'hFFFFFFE0, 32'h0000162E, 1'b0};
    vecs[12] = '{OP_ADDI,  5'b00000, 32'h0000162E, 32'h0000F0F0, 32'h0001071E, 1'b0};
    vecs[13] = '{OP_ORI,   5'b00000, 32'h0000162E, 32'h0000F0F0, 32'h0000F6FE, 1'b0};
    vecs[14] = '{OP_XORI,  5'b00000, 32'h0000162E, 32'h0000F0F0, 32'h0000E6DE, 1'b0};
    vecs[15] = '{OP_MOVI,  5'b00000, 32'h0000162E, 32'h0000F0F0, 32'h0000F0F0, 1'b0};
    vecs[16] = '{OP_ARITH, ADD,      32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vecs[17] = '{OP_ARITH, SUB,      32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vecs[18] = '{OP_ARITH, ADD,      32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[19] = '{OP_ARITH, 5'b11111, 32'h0000162E, 32'h000004D2, 32'h00000000, 1'b0};
    vecs[20] = '{6'b000000, ADD,     32'h0000162E, 32'h000004D2, 32'h00000000, 1'b0};
    vecs[21] = '{OP_ADDI,  5'b00000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1};
    vecs[22] = '{OP_ARITH, SUB,      32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    vecs[23] = '{OP_ARITH, SUB,      32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[24] = '{OP_ARITH, ROTRI,    32'h00000001, 32'h0000001F, 32'h00000002, 1'b0};
    vecs[25] = '{OP_ARITH, SLLI,     32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};

    valid_ops = '{OP_ARITH, OP_ADDI, OP_XORI, OP_ORI, OP_MOVI};
    valid_fns = '{ADD, SUB, AND, XOR, OR, SLLI, SRLI, ROTRI};

    // Load a value first so the asynchronous clear is observable.
    reset = 1'b1;
    drive(OP_ARITH, ADD, 32'd5, 32'd7, 1'b1);
    step();
    check32("preload_result", alu_result, 32'd12);

    #2 reset = 1'b0;
    #1;
    check32("async_reset_result", alu_result, 32'h0);
    check1("async_reset_ovf", alu_overflow, 1'b0);

    for (int i = 0; i < 3; i++) begin
      drive(OP_ARITH, ADD, $urandom, $urandom, 1'b1);
      step();
      check32("reset_hold_result", alu_result, 32'h0);
    end

    // Release with enable low: outputs stay clear.
    drive(OP_ARITH, ADD, 32'h0000162E, 32'h000004D2, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check32("enable_low_result", alu_result, 32'h0);
      check1("enable_low_ovf", alu_overflow, 1'b0);
    end

    // Directed vectors, one enabled edge each.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, 1'b1);
      step();
      check32($sformatf("vec%0d_result", i), alu_result, vecs[i].res);
      check1($sformatf("vec%0d_ovf", i), alu_overflow, vecs[i].ovf);
    end

    // Valid ADD, then enable dropped for one edge.
    drive(OP_ARITH, ADD, 32'h0000162E, 32'h000004D2, 1'b1);
    step();
    check32("seq_add_result", alu_result, 32'h00001B00);
    enable_execute = 1'b0;
    step();
    check32("seq_enable_drop_result", alu_result, 32'h0);

    // Operand changes between edges are not visible until the next edge.
    drive(OP_ARITH, ADD, 32'h7FFFFFFF, 32'h00000001, 1'b1);
    step();
    drive(OP_MOVI, 5'b00000, 32'h0, 32'h12345678, 1'b1);
    #3;
    check32("hold_between_edges_result", alu_result, 32'h80000000);
    check1("hold_between_edges_ovf", alu_overflow, 1'b1);
    step();
    check32("next_edge_result", alu_result, 32'h12345678);
    check1("next_edge_ovf", alu_overflow, 1'b0);

    // Reset mid-cycle, then the first enabled edge after release computes normally.
    #2 reset = 1'b0;
    #1;
    check32("midcycle_reset_result", alu_result, 32'h0);
    step();
    drive(OP_XORI, 5'b00000, 32'h0000162E, 32'h0000F0F0, 1'b1);
    reset = 1'b1;
    step();
    check32("post_release_result", alu_result, 32'h0000E6DE);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: rop = 6'($urandom);
        default: rop = valid_ops[$urandom_range(0, 4)];
      endcase
      case ($urandom_range(0, 5))
        0: rfn = 5'($urandom);
        default: rfn = valid_fns[$urandom_range(0, 7)];
      endcase
      ren = ($urandom_range(0, 7) != 0);
      drive(rop, rfn, $urandom, $urandom, ren);
      if (ren) begin
        model(rop, rfn, scr1, scr2, exp_r, exp_v);
      end else begin
        exp_r = 32'h0;
        exp_v = 1'b0;
      end
      step();
      check32($sformatf("rand%0d_result op=%06b fn=%05b a=%08h b=%08h", i, rop, rfn, scr1, scr2),
              alu_result, exp_r);
      check1($sformatf("rand%0d_ovf op=%06b fn=%05b", i, rop, rfn), alu_overflow, exp_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Single-cycle-latency integer ALU for the execute stage of the 32-bit core.
- Decodes a 6-bit major opcode and, for register-register arithmetic, a 5-bit sub-opcode.
- Computes add/sub/logic/shift/rotate/immediate results on two 32-bit source operands.
- Registers the result and a signed-overflow flag on the rising clock edge when execution is enabled.

Parameters:
- DATA_W, 32, operand/result width. Only 32 is required to be supported; the shift-amount width is fixed at 5.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-low reset; 0 clears all outputs immediately
- scr1  input  32  source operand 1 (rs1 value)
- scr2  input  32  source operand 2 (rs2 value, or the immediate already extended to 32 bits by the decoder)
- opcode  input  6  major opcode
- sub_opcode  input  5  function select, used only when opcode = OP_ARITH
- enable_execute  input  1  execute strobe, sampled on the rising edge of clk
- alu_result  output  32  registered result
- alu_overflow  output  1  registered signed-overflow flag

Behaviour:
- Reset (reset=0, asynchronous):
  - alu_result=0 and alu_overflow=0 immediately.
  - Outputs are held at 0 while reset stays low, regardless of enable_execute.
- Rising clk edge with reset=1:
  - enable_execute=1: alu_result and alu_overflow load the combinational result of the current inputs. Latency is 1 cycle.
  - enable_execute=0: alu_result<=0 and alu_overflow<=0.
  - The enable is level-sampled each cycle; there is no handshake and no busy state.
- Opcode map:
  - OP_ARITH=6'b100000: operation selected by sub_opcode.
  - OP_ADDI=6'b101000: scr1+scr2.
  - OP_XORI=6'b101011: scr1^scr2.
  - OP_ORI=6'b101100: scr1|scr2.
  - OP_MOVI=6'b100010: result=scr2.
- Sub-opcode map under OP_ARITH:
  - ADD=00000: scr1+scr2.
  - SUB=00001: scr1-scr2.
  - AND=00010: scr1&scr2.
  - XOR=00011: scr1^scr2.
  - OR=00100: scr1|scr2.
  - SLLI=01000: scr1<<scr2[4:0], zero fill.
  - SRLI=01001: scr1>>scr2[4:0], logical, zero fill.
  - ROTRI=01011: scr1 rotated right by scr2[4:0].
- NOP has no dedicated code. NOP is encoded as SRLI (01001) and produces whatever SRLI computes.
- Shift amount: only scr2[4:0] is used; scr2[31:5] is ignored. A shift or rotate by 0 returns scr1 unchanged.
- Add/sub arithmetic:
  - Results wrap modulo 2^32; no carry output.
  - Immediate ops use scr2 unmodified. All sign/zero extension is done upstream.
- alu_overflow:
  - ADD/ADDI: 1 when both operands have equal sign bits and the result sign differs.
  - SUB: 1 when the operand signs differ and the result sign differs from scr1's sign.
  - All other operations: 0.
- Undefined opcode, or undefined sub_opcode under OP_ARITH: result 0, overflow 0. No exception.
- Changes to scr1/scr2/opcode/sub_opcode between edges have no effect until the next enabled edge.
- Reset asserted mid-operation: outputs clear immediately. On reset release, the first enabled edge computes normally.

Decomposition:
- Package alu_pkg holds the opcode constants (OP_ARITH, OP_ADDI, OP_ORI, OP_XORI, OP_MOVI) and the sub-opcode constants (ADD, SUB, AND, XOR, OR, SLLI, SRLI, ROTRI, plus NOP aliased to SRLI).
- One sub-module, alu_shifter: a combinational 5-stage barrel shifter with mode select (SLL/SRL/ROTR).
- The adder, logic ops, overflow detection and output register stay in alu.

Test Plan:
- Reset and enable gating:
  - Assert reset=0 with enable_execute=1 and random operands -> outputs 0 immediately and across edges.
  - Release reset, enable_execute=0 -> outputs stay 0.
- Arithmetic and logic, scr1=0x0000162E, scr2=0x000004D2, OP_ARITH, one enabled edge each:
  - ADD -> 0x00001B00
  - SUB -> 0x0000115C
  - AND -> 0x00000402
  - OR -> 0x000016FE
  - XOR -> 0x000012FC
  - alu_overflow=0 throughout.
- NOP and shifts:
  - NOP (SRLI code) with scr1=0x162E, scr2=0x4D2 (shift 18) -> 0.
  - With scr2=3: SRLI -> 0x000002C5, SLLI -> 0x0000B170, ROTRI -> 0xC00002C5.
  - Shift amount 0 -> 0x0000162E.
- Immediate ops, scr1=0x0000162E, scr2=0x0000F0F0:
  - ADDI -> 0x0001071E
  - ORI -> 0x0000F6FE
  - XORI -> 0x0000E6DE
  - MOVI -> 0x0000F0F0
- Overflow:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
  - SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
  - ADD 0xFFFFFFFF+1 -> 0, overflow=0.
- Enable-low clearing: after a valid ADD, drop enable_execute for one edge -> outputs return to 0. An undefined sub_opcode 5'b11111 -> 0.
